// File: rtl/pitch_synth_pkg.sv
// pitch_synth_pkg: shared FSM state type, parameter defaults and the
// elaboration-time quarter-wave sine table generator for pitch_tone_synth.
package pitch_synth_pkg;

    localparam int LUT_AW_DEF  = 8;
    localparam int PHASE_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALC    = 2'd1,
        ST_READ    = 2'd2,
        ST_PRESENT = 2'd3
    } state_e;

    // Fixed-point helpers work in Q60 on 128-bit signed values.
    typedef logic signed [127:0] wide_t;
    localparam int FRAC = 60;

    // atan(1/m) by its Taylor series, used to build pi (Machin).
    function automatic wide_t atan_inv(input int m);
        wide_t t;
        wide_t s;
        t = (wide_t'(1) <<< FRAC) / wide_t'(m);
        s = t;
        for (int n = 1; n < 40; n++) begin
            t = t / wide_t'(m * m);
            if (n % 2 == 1)
                s = s - t / wide_t'(2 * n + 1);
            else
                s = s + t / wide_t'(2 * n + 1);
        end
        return s;
    endfunction

    // Entry k = round((2^(w-1)-1) * sin(pi/2 * (k+0.5) / 2^aw)).
    function automatic int sine_lut(input int k, input int w, input int aw);
        wide_t pi;
        wide_t x;
        wide_t x2;
        wide_t term;
        wide_t sum;
        wide_t full;
        pi   = wide_t'(16) * atan_inv(5) - wide_t'(4) * atan_inv(239);
        x    = (pi * wide_t'(2 * k + 1)) >>> (aw + 2);
        x2   = (x * x) >>> FRAC;
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -((term * x2) >>> FRAC) / wide_t'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        full = (wide_t'(1) <<< (w - 1)) - 1;
        return int'((sum * full + (wide_t'(1) <<< (FRAC - 1))) >>> FRAC);
    endfunction

endpackage

// File: rtl/dstream.sv
// dstream: data stream with valid/ready handshake.
// Ports: valid, ready, data[N-1:0]; modports source and sink.
interface dstream #(
    parameter int N = 8
);
    logic         valid;
    logic         ready;
    logic [N-1:0] data;

    modport source (output valid, output data, input ready);
    modport sink   (input valid, input data, output ready);
endinterface

// File: rtl/pitch_tone_synth_sine_quarter_lut.sv
// sine_quarter_lut: synchronous quarter-wave sine ROM, one-cycle read,
// no reset. Ports: clk, addr[AW-1:0], data[W-2:0] (unsigned magnitude).
module sine_quarter_lut
    import pitch_synth_pkg::*;
#(
    parameter int AW = LUT_AW_DEF,
    parameter int W  = 16
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output logic [W-2:0]  data
);

    localparam int DW    = W - 1;
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] rom [DEPTH];
    logic [DW-1:0] data_d;
    logic [DW-1:0] data_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [DW-1:0] VAL = DW'(sine_lut(k, W, AW));
        assign rom[k] = VAL;
    end

    assign data_d = rom[addr];
    assign data   = data_q;

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

endmodule

// File: rtl/pitch_tone_synth.sv
// pitch_tone_synth: turns FFT pitch bin indices into a continuous sine
// tone at bin*Fs/NSAMPLES, one sample per downstream handshake.
// Ports: clk; reset (async, active-high); pitch_input (dstream sink,
// bin index); audio_output (dstream source, signed W-bit sample).
// Option: define PITCH_SYNTH_RAMP_EN for a 16-step amplitude fade
// in/out; otherwise the tone switches hard between full scale and 0.
module pitch_tone_synth
    import pitch_synth_pkg::*;
#(
    parameter int NSAMPLES = 1024,
    parameter int W        = 16,
    parameter int PHASE_W  = PHASE_W_DEF,
    parameter int LUT_AW   = LUT_AW_DEF
) (
    input  logic   clk,
    input  logic   reset,
    dstream.sink   pitch_input,
    dstream.source audio_output
);

    localparam int BW    = $clog2(NSAMPLES);
    localparam int SHIFT = PHASE_W - BW;
    localparam int DW    = W - 1;

    state_e             state_q, state_d;
    logic [BW-1:0]      pend_bin_q, pend_bin_d;
    logic [PHASE_W-1:0] inc_q, inc_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               neg_q, neg_d;
    logic [W-1:0]       data_q, data_d;

    logic [1:0]         quad_now;
    logic [LUT_AW-1:0]  addr_raw;
    logic [LUT_AW-1:0]  lut_addr;
    logic [DW-1:0]      lut_data;
    logic [W-1:0]       signed_lut;
    logic [W-1:0]       sample;

    assign pitch_input.ready  = 1'b1;
    assign audio_output.valid = (state_q == ST_PRESENT);
    assign audio_output.data  = data_q;

    // Odd quadrants read the quarter wave backwards.
    assign quad_now = phase_q[PHASE_W-1 -: 2];
    assign addr_raw = phase_q[PHASE_W-3 -: LUT_AW];
    assign lut_addr = quad_now[0] ? ~addr_raw : addr_raw;

    // The ROM's own address register is the CALC-stage address flop.
    sine_quarter_lut #(
        .AW (LUT_AW),
        .W  (W)
    ) u_lut (
        .clk  (clk),
        .addr (lut_addr),
        .data (lut_data)
    );

    // The table never holds -2^(W-1), so negation is safe.
    assign signed_lut = neg_q ? -{1'b0, lut_data} : {1'b0, lut_data};

`ifdef PITCH_SYNTH_RAMP_EN
    logic [4:0]          amp_q, amp_d;
    logic signed [W+4:0] lut_ext;
    logic signed [W+4:0] amp_ext;
    logic signed [W+4:0] prod;

    assign lut_ext = {{5{signed_lut[W-1]}}, signed_lut};
    assign amp_ext = {{W{1'b0}}, amp_q};
    assign prod    = lut_ext * amp_ext;
    assign sample  = prod[W+3:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            amp_q <= 5'd0;
        end else begin
            amp_q <= amp_d;
        end
    end
`else
    assign sample = (inc_q != '0) ? signed_lut : '0;
`endif

    always_comb begin
        pend_bin_d = pend_bin_q;
        if (pitch_input.valid) begin
            // Above Nyquist folds to bin 0, i.e. mute.
            pend_bin_d = pitch_input.data[BW-1] ? '0 : pitch_input.data;
        end
    end

    always_comb begin
        state_d = state_q;
        inc_d   = inc_q;
        phase_d = phase_q;
        neg_d   = neg_q;
        data_d  = data_q;
`ifdef PITCH_SYNTH_RAMP_EN
        amp_d   = amp_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pitch_input.valid) begin
                    inc_d   = {pend_bin_d, {SHIFT{1'b0}}};
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                neg_d   = quad_now[1];
                state_d = ST_READ;
            end
            ST_READ: begin
                data_d  = sample;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (audio_output.ready) begin
                    // Step with the old increment; the new pitch
                    // governs the steps after this one.
                    phase_d = phase_q + inc_q;
                    inc_d   = {pend_bin_d, {SHIFT{1'b0}}};
`ifdef PITCH_SYNTH_RAMP_EN
                    if (inc_d != '0 && amp_q != 5'd16)
                        amp_d = amp_q + 5'd1;
                    else if (inc_d == '0 && amp_q != 5'd0)
                        amp_d = amp_q - 5'd1;
`endif
                    state_d = ST_CALC;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pend_bin_q <= '0;
            inc_q      <= '0;
            phase_q    <= '0;
            neg_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_bin_q <= pend_bin_d;
            inc_q      <= inc_d;
            phase_q    <= phase_d;
            neg_q      <= neg_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_pitch_tone_synth.sv
// tb_pitch_tone_synth: directed stimulus with a queue scoreboard for
// pitch_tone_synth; a negedge monitor checks every output handshake.
`timescale 1ns/1ps
module tb_pitch_tone_synth;

    localparam int NS    = 1024;
    localparam int W     = 16;
    localparam int BW    = 10;
    localparam int SHIFT = 14;
    localparam int unsigned MASK = 32'h00FF_FFFF;

    logic clk = 1'b0;
    logic reset;

    dstream #(.N(BW)) pin ();
    dstream #(.N(W))  aout ();

    pitch_tone_synth #(
        .NSAMPLES (NS),
        .W        (W),
        .PHASE_W  (24),
        .LUT_AW   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pitch_input  (pin),
        .audio_output (aout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int mon_exp;
    int stall_exp;
    int lat;
    int tab[8];

    int unsigned m_phase;
    int unsigned m_inc;
    int unsigned m_pend;
    int unsigned m_amp;
    bit          m_started;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int lut_ref(int k);
        real x;
        x = 3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / 256.0;
        return $rtoi(32767.0 * $sin(x) + 0.5);
    endfunction

    function automatic int model_val();
        int q;
        int a;
        int l;
        int s;
        q = int'(m_phase >> 22) & 3;
        a = int'(m_phase >> 14) & 255;
        l = lut_ref((q & 1) != 0 ? 255 - a : a);
        s = (q & 2) != 0 ? -l : l;
`ifdef PITCH_SYNTH_RAMP_EN
        return (s * int'(m_amp)) >>> 4;
`else
        return (m_inc != 0) ? s : 0;
`endif
    endfunction

    task automatic model_adv();
        m_phase = (m_phase + m_inc) & MASK;
        m_inc   = m_pend << SHIFT;
`ifdef PITCH_SYNTH_RAMP_EN
        if (m_inc != 0 && m_amp < 16)
            m_amp++;
        else if (m_inc == 0 && m_amp > 0)
            m_amp--;
`endif
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_inc     = 0;
        m_pend    = 0;
        m_amp     = 0;
        m_started = 0;
        exp_q.delete();
    endtask

    task automatic push_run(int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model_val());
            model_adv();
        end
    endtask

    task automatic send_pitch(int bin);
        pin.data  = BW'(bin);
        pin.valid = 1'b1;
        @(posedge clk);
        #1;
        pin.valid = 1'b0;
        m_pend = (bin >= NS / 2) ? 0 : bin;
        if (!m_started) begin
            m_started = 1;
            m_inc     = m_pend << SHIFT;
        end
    endtask

    task automatic drain(int budget, string tag);
        aout.ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                aout.ready = 1'b0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s: timeout, %0d samples outstanding, want 0",
                 tag, exp_q.size());
        exp_q.delete();
        aout.ready = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && aout.valid && aout.ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sample: got %0d want none",
                         int'($signed(aout.data)));
            end else begin
                mon_exp = exp_q.pop_front();
                check("sample", int'($signed(aout.data)), mon_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef PITCH_SYNTH_RAMP_EN
        tab = '{0, 2047, -13, -6144, 25, 10239, -38, -14336};
`else
        tab = '{101, 32767, -101, -32767, 101, 32767, -101, -32767};
`endif
        reset      = 1'b1;
        pin.valid  = 1'b0;
        pin.data   = '0;
        aout.ready = 1'b1;
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        check("reset_valid", int'(aout.valid), 0);
        check("reset_data", int'($signed(aout.data)), 0);
        check("reset_pin_ready", int'(pin.ready), 1);
        reset = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("idle_valid", int'(aout.valid), 0);
        end

        // Bin 256: quarter-period steps, hand table first.
        send_pitch(256);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(tab[i]);
            model_adv();
        end
        push_run(24);
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (aout.valid) begin
                lat = i;
                break;
            end
        end
        check("first_latency", lat, 3);
        drain(200, "bin256");

        // Stall in PRESENT; change pitch mid-stall.
        for (int c = 0; c < 10 && !aout.valid; c++) @(negedge clk);
        check("stall_valid", int'(aout.valid), 1);
        stall_exp = model_val();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_data", int'($signed(aout.data)), stall_exp);
        end
        send_pitch(128);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_data2", int'($signed(aout.data)), stall_exp);
            check("stall_valid2", int'(aout.valid), 1);
        end
        push_run(8);
        drain(100, "bin128");

        // Above Nyquist mutes.
        send_pitch(600);
        push_run(20);
        drain(200, "nyquist");

        // Bin 256 then bin 0.
        send_pitch(256);
        push_run(20);
        drain(200, "bin256b");
        send_pitch(0);
        push_run(20);
        drain(200, "mute");

        // Async reset while a sample is held.
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_valid", int'(aout.valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_valid", int'(aout.valid), 0);
        check("async_reset_data", int'($signed(aout.data)), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Bin 1: one full period over 1024 samples.
        send_pitch(1);
        push_run(1024);
        exp_q.push_back(101);
        model_adv();
        drain(3300, "bin1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
